// File: rtl/dcmi_pkg.sv
// Shared types and constants for the DCMI DMA sequencer.
package dcmi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    FETCH    = 2'd2,
    WRITE    = 2'd3
  } state_t;

  // Byte step between consecutive 32-bit words on the bus.
  localparam int unsigned ADDR_INC = 4;

endpackage

// File: rtl/dcmi_dma_ctrl.sv
// Drains the DCMI ping-pong buffer into memory one word per bus beat,
// framing the transfer with a programmed base address and word count.
module dcmi_dma_ctrl
  import dcmi_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_en,
  input  logic             cfg_snapshot,
  input  logic [AW-1:0]    cfg_base_addr,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             frame_start,
  output logic             pp_block_en,
  input  logic             pp_rd_rdy,
  output logic             pp_rd_req,
  input  logic [31:0]      pp_rd_data,
  input  logic             pp_ovf,
  output logic             bus_req,
  output logic [AW-1:0]    bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic             bus_ack,
  output logic             frame_done,
  output logic             busy,
  output logic             err_ovf,
  input  logic             err_clr
);

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, addr_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic             snap_q;
  logic             frame_drop_q;
  logic [31:0]      wdata_q;
  logic             frame_done_q;
  logic             err_ovf_q;

  logic ovf_act;    // overflow that matters: buffer is live
  logic drop_now;   // current frame is being abandoned
  logic pop;        // word moves from buffer to write register
  logic last_beat;  // beat in flight is the final word of the frame

  // Qualify overflow, pop and end-of-frame conditions.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ovf_act   = pp_ovf && ((state_q == FETCH) || (state_q == WRITE));
    drop_now  = frame_drop_q || ovf_act;
    pop       = (state_q == FETCH) && pp_rd_rdy && !drop_now;
    last_beat = (cnt_q == (len_q - CNT_W'(1)));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here -- it is only seen on a clock edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a started bus beat always runs to its ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_en && (cfg_len != '0)) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!ctrl_en)         state_d = IDLE;
        else if (frame_start) state_d = FETCH;
      end
      FETCH: begin
        if (drop_now)      state_d = WAIT_SOF;
        else if (pop)      state_d = WRITE;
        else if (!ctrl_en) state_d = IDLE;
      end
      WRITE: begin
        if (bus_ack) begin
          if (drop_now)       state_d = WAIT_SOF;
          else if (last_beat) state_d = (snap_q || !ctrl_en) ? IDLE : WAIT_SOF;
          else if (!ctrl_en)  state_d = IDLE;
          else                state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config latch, address/count datapath, write data and status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      base_q       <= '0;
      len_q        <= '0;
      snap_q       <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      frame_drop_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if ((state_q == IDLE) && (state_d == WAIT_SOF)) begin
        base_q <= cfg_base_addr;
        len_q  <= cfg_len;
        snap_q <= cfg_snapshot;
      end

      if ((state_q == WAIT_SOF) && (state_d == FETCH)) begin
        addr_q       <= base_q;
        cnt_q        <= '0;
        frame_drop_q <= 1'b0;
      end

      if (pop) wdata_q <= pp_rd_data;

      if ((state_q == WRITE) && bus_ack) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        addr_q <= addr_q + AW'(ADDR_INC);
        if (last_beat && !drop_now) frame_done_q <= 1'b1;
      end

      if (ovf_act) frame_drop_q <= 1'b1;

      // A new overflow outranks a simultaneous clear.
      if (ovf_act)      err_ovf_q <= 1'b1;
      else if (err_clr) err_ovf_q <= 1'b0;
    end
  end

  assign pp_block_en = (state_q == FETCH) || (state_q == WRITE);
  assign pp_rd_req   = pop;
  assign bus_req     = (state_q == WRITE);
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != IDLE);
  assign err_ovf     = err_ovf_q;

endmodule
